vmx_tile_buffer: RTL and testbench

//  Local operand/result store and sequencer directly in front of vmx_mm_wrapper.

---
 rtl/vmx_tile_buffer_if.sv | 48 ++++
 rtl/vmx_tile_buffer.sv | 155 +++++++++++++++
 tb/tb_vmx_tile_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/vmx_tile_buffer_if.sv
// Host and engine signal bundle for vmx_tile_buffer.
// The slave modport is the buffer's view; master is the host/engine side.
interface vmx_tile_buffer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DIN_WIDTH  = 64,
  parameter int DOUT_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) ();
  // Host side
  logic                  host_wr_en;
  logic [ADDR_WIDTH-1:0] host_wr_addr;
  logic [DIN_WIDTH-1:0]  host_wr_data;
  logic                  host_rd_en;
  logic [ADDR_WIDTH-1:0] host_rd_addr;
  logic [DOUT_WIDTH-1:0] host_rd_data;
  logic                  host_rd_valid;
  logic                  host_start;
  logic                  host_simd;
  logic                  host_clear;
  logic                  host_busy;
  logic                  host_done;
  logic                  host_err;
  logic [1:0]            host_err_code;
  logic [CNT_WIDTH-1:0]  host_cycles;
  // Engine side
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic                  eng_wr_en;
  logic [DOUT_WIDTH-1:0] eng_d_o;
  logic [DIN_WIDTH-1:0]  eng_d_i;
  logic [31:0]           eng_ctrl;
  logic [31:0]           eng_flag;

  modport slave (
    input  host_wr_en, host_wr_addr, host_wr_data, host_rd_en, host_rd_addr,
           host_start, host_simd, host_clear,
           eng_addr, eng_wr_en, eng_d_o, eng_flag,
    output host_rd_data, host_rd_valid, host_busy, host_done, host_err,
           host_err_code, host_cycles, eng_d_i, eng_ctrl
  );

  modport master (
    output host_wr_en, host_wr_addr, host_wr_data, host_rd_en, host_rd_addr,
           host_start, host_simd, host_clear,
           eng_addr, eng_wr_en, eng_d_o, eng_flag,
    input  host_rd_data, host_rd_valid, host_busy, host_done, host_err,
           host_err_code, host_cycles, eng_d_i, eng_ctrl
  );
endinterface

// File: rtl/vmx_tile_buffer.sv
// Operand/result store and job sequencer in front of vmx_mm_wrapper.
// Host loads the input RAM and starts a job; the block arms the engine,
// serves its operand reads, captures its results and reports completion.
module vmx_tile_buffer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DIN_WIDTH   = 64,
  parameter int DOUT_WIDTH  = 128,
  parameter int ARM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  vmx_tile_buffer_if.slave    bus_if
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int TMR_W = $clog2(ARM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  simd_q, simd_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [CNT_WIDTH-1:0]  cycles_q, cycles_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  busy_q, busy_d;
  logic [31:0]           eng_ctrl_q, eng_ctrl_d;
  logic [DIN_WIDTH-1:0]  eng_d_i_q;
  logic [DOUT_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  logic [DIN_WIDTH-1:0]  in_mem  [DEPTH];
  logic [DOUT_WIDTH-1:0] out_mem [DEPTH];

  logic is_busy;
  assign is_busy = (state_q == S_ARM) || (state_q == S_RUN);

  // Next-state, job bookkeeping and sticky flag logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    simd_d     = simd_q;
    timer_d    = timer_q;
    cycles_d   = cycles_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    // done is cleared ahead of completion so a finishing job is never lost.
    if (bus_if.host_clear) done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus_if.host_start) begin
          state_d  = S_ARM;
          simd_d   = bus_if.host_simd;
          timer_d  = '0;
          cycles_d = '0;
          done_d   = 1'b0;
        end
      end
      S_ARM: begin
        cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
        if (bus_if.eng_flag != 32'd0) begin
          state_d = S_RUN;
        end else if (timer_q == TMR_W'(ARM_TIMEOUT - 1)) begin
          state_d       = S_IDLE;
          err_d         = 1'b1;
          err_code_d[0] = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RUN: begin
        cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
        if (bus_if.eng_flag == 32'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Host writes or starts while a job is in flight are rejected and flagged.
    if (is_busy && (bus_if.host_wr_en || bus_if.host_start)) begin
      err_d         = 1'b1;
      err_code_d[1] = 1'b1;
    end

    // Clear wins over any error raised in the same cycle.
    if (bus_if.host_clear) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end

    // Outputs are registered from the next state so they line up with it.
    busy_d     = (state_d == S_ARM) || (state_d == S_RUN);
    eng_ctrl_d = (state_d == S_ARM) ? {30'b0, simd_d, 1'b1} : 32'd0;
  end

  // Control registers and registered read ports, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      simd_q     <= 1'b0;
      timer_q    <= '0;
      cycles_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      busy_q     <= 1'b0;
      eng_ctrl_q <= 32'd0;
      eng_d_i_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      simd_q     <= simd_d;
      timer_q    <= timer_d;
      cycles_q   <= cycles_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
      eng_ctrl_q <= eng_ctrl_d;
      eng_d_i_q  <= in_mem[bus_if.eng_addr];
      rd_data_q  <= out_mem[bus_if.host_rd_addr];
      rd_valid_q <= bus_if.host_rd_en;
    end
  end

  // RAM write ports; reads above sample the old word on a same-address write.
  always_ff @(posedge clk) begin
    // NOTE: the RAM arrays have no reset so they map onto block RAM and keep contents across reset.
    if (rst_n) begin
      if (bus_if.host_wr_en && !is_busy) in_mem[bus_if.host_wr_addr] <= bus_if.host_wr_data;
      if (bus_if.eng_wr_en)              out_mem[bus_if.eng_addr]    <= bus_if.eng_d_o;
    end
  end

  assign bus_if.host_rd_data  = rd_data_q;
  assign bus_if.host_rd_valid = rd_valid_q;
  assign bus_if.host_busy     = busy_q;
  assign bus_if.host_done     = done_q;
  assign bus_if.host_err      = err_q;
  assign bus_if.host_err_code = err_code_q;
  assign bus_if.host_cycles   = cycles_q;
  assign bus_if.eng_d_i       = eng_d_i_q;
  assign bus_if.eng_ctrl      = eng_ctrl_q;

endmodule

// File: tb/tb_vmx_tile_buffer.sv
// Self-checking bench for vmx_tile_buffer: randomized RAM traffic against
// array models, plus directed job, timeout, illegal-access and reset steps.
module tb_vmx_tile_buffer;

  localparam int ARM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vmx_tile_buffer_if bus_if ();

  vmx_tile_buffer #(
    .ADDR_WIDTH(8), .DIN_WIDTH(64), .DOUT_WIDTH(128),
    .ARM_TIMEOUT(ARM_TIMEOUT), .CNT_WIDTH(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0]  in_ref  [256];
  logic [127:0] out_ref [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   ha, ea, ra;
    logic [63:0]  hd, exp_eng;
    logic [127:0] ed, exp_rd;
    logic         hw, ew, re;
    int           n, d, m;

    rst_n = 1'b0;
    bus_if.host_wr_en = 0; bus_if.host_wr_addr = 0; bus_if.host_wr_data = 0;
    bus_if.host_rd_en = 0; bus_if.host_rd_addr = 0;
    bus_if.host_start = 0; bus_if.host_simd = 0; bus_if.host_clear = 0;
    bus_if.eng_addr = 0; bus_if.eng_wr_en = 0; bus_if.eng_d_o = 0; bus_if.eng_flag = 0;
    tick(); tick();

    // Reset state
    check("rst_busy",     bus_if.host_busy, 0);
    check("rst_done",     bus_if.host_done, 0);
    check("rst_err",      bus_if.host_err, 0);
    check("rst_err_code", bus_if.host_err_code, 0);
    check("rst_cycles",   bus_if.host_cycles, 0);
    check("rst_ctrl",     bus_if.eng_ctrl, 0);
    check("rst_rd_valid", bus_if.host_rd_valid, 0);
    check("rst_rd_data",  bus_if.host_rd_data, 0);
    check("rst_eng_d_i",  bus_if.eng_d_i, 0);
    rst_n = 1'b1;

    // Fill both RAMs with random contents so the models are fully known.
    for (int i = 0; i < 256; i++) begin
      hd = {$urandom, $urandom};
      ed = {$urandom, $urandom, $urandom, $urandom};
      bus_if.host_wr_en = 1; bus_if.host_wr_addr = 8'(i); bus_if.host_wr_data = hd;
      bus_if.eng_wr_en = 1;  bus_if.eng_addr = 8'(i);     bus_if.eng_d_o = ed;
      in_ref[i] = hd; out_ref[i] = ed;
      tick();
    end
    bus_if.eng_wr_en = 0;

    // Operand load and engine read latency
    for (int i = 0; i < 4; i++) begin
      hd = 64'h0001_0002_0003_0004 + 64'(i);
      bus_if.host_wr_addr = 8'(i); bus_if.host_wr_data = hd;
      in_ref[i] = hd;
      tick();
    end
    bus_if.host_wr_en = 0;
    bus_if.eng_addr = 8'd2;
    tick();
    check("load_eng_d_i", bus_if.eng_d_i, 64'h0001_0002_0003_0006);

    // Randomized RAM traffic with forced same-address collisions.
    for (int k = 0; k < 60; k++) begin
      hw = 1'($urandom); ew = 1'($urandom); re = 1'($urandom);
      ha = 8'($urandom); ea = 8'($urandom); ra = 8'($urandom);
      hd = {$urandom, $urandom};
      ed = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin ha = ea; ra = ea; end
      exp_eng = in_ref[ea];
      exp_rd  = out_ref[ra];
      if (hw) in_ref[ha]  = hd;
      if (ew) out_ref[ea] = ed;
      bus_if.host_wr_en = hw; bus_if.host_wr_addr = ha; bus_if.host_wr_data = hd;
      bus_if.eng_wr_en  = ew; bus_if.eng_addr = ea;     bus_if.eng_d_o = ed;
      bus_if.host_rd_en = re; bus_if.host_rd_addr = ra;
      tick();
      check("rand_eng_d_i",  bus_if.eng_d_i, exp_eng);
      check("rand_rd_data",  bus_if.host_rd_data, exp_rd);
      check("rand_rd_valid", bus_if.host_rd_valid, re);
    end
    bus_if.host_wr_en = 0; bus_if.eng_wr_en = 0; bus_if.host_rd_en = 0;

    // Engine write-back then host read
    for (int i = 0; i < 4; i++) begin
      bus_if.eng_wr_en = 1; bus_if.eng_addr = 8'(2 * i); bus_if.eng_d_o = 128'hA0 + 128'(i);
      out_ref[2 * i] = 128'hA0 + 128'(i);
      tick();
    end
    bus_if.eng_wr_en = 0;
    bus_if.host_rd_en = 1; bus_if.host_rd_addr = 8'd4;
    tick();
    check("wb_rd_valid", bus_if.host_rd_valid, 1);
    check("wb_rd_data",  bus_if.host_rd_data, 128'hA2);
    bus_if.host_rd_en = 0;
    tick();
    check("wb_rd_valid_drop", bus_if.host_rd_valid, 0);

    // Full SIMD job: flag stays 0 for d ARM cycles, then nonzero for m cycles.
    d = 1; m = 14;
    bus_if.host_simd = 1; bus_if.host_start = 1;
    tick();
    bus_if.host_start = 0; bus_if.host_simd = 0;
    check("job_busy", bus_if.host_busy, 1);
    check("job_ctrl_arm", bus_if.eng_ctrl, 32'h3);
    for (int i = 0; i < d; i++) tick();
    check("job_ctrl_hold", bus_if.eng_ctrl, 32'h3);
    for (int i = 0; i < m; i++) begin
      bus_if.eng_flag = 32'((i % 4) + 1);
      tick();
      if (i == 0) check("job_ctrl_run", bus_if.eng_ctrl, 0);
    end
    check("job_busy_run", bus_if.host_busy, 1);
    bus_if.eng_flag = 0;
    tick();
    check("job_done",   bus_if.host_done, 1);
    check("job_idle",   bus_if.host_busy, 0);
    check("job_cycles", bus_if.host_cycles, 16'(d + m + 1));
    tick();
    check("job_done_sticky", bus_if.host_done, 1);
    check("job_err", bus_if.host_err, 0);

    // ARM timeout with the engine never responding.
    bus_if.host_start = 1;
    tick();
    bus_if.host_start = 0;
    check("to_ctrl", bus_if.eng_ctrl, 32'h1);
    check("to_done_cleared", bus_if.host_done, 0);
    n = 0;
    while (bus_if.eng_ctrl !== 32'd0 && n < 3 * ARM_TIMEOUT) begin
      tick();
      n++;
    end
    check("to_length",   n, ARM_TIMEOUT);
    check("to_err",      bus_if.host_err, 1);
    check("to_err_code", bus_if.host_err_code, 2'b01);
    check("to_done",     bus_if.host_done, 0);
    check("to_busy",     bus_if.host_busy, 0);
    check("to_cycles",   bus_if.host_cycles, 16'(ARM_TIMEOUT));
    bus_if.host_clear = 1;
    tick();
    bus_if.host_clear = 0;
    check("to_clear_err",  bus_if.host_err, 0);
    check("to_clear_code", bus_if.host_err_code, 0);

    // Illegal accesses during RUN.
    bus_if.eng_flag = 2; bus_if.host_start = 1;
    tick();
    bus_if.host_start = 0;
    tick();
    check("ill_busy", bus_if.host_busy, 1);
    bus_if.host_wr_en = 1; bus_if.host_wr_addr = 8'd5; bus_if.host_wr_data = ~in_ref[5];
    tick();
    check("ill_err",      bus_if.host_err, 1);
    check("ill_err_code", bus_if.host_err_code, 2'b10);
    bus_if.host_clear = 1;
    tick();
    bus_if.host_clear = 0; bus_if.host_wr_en = 0;
    check("ill_clear_prio_err",  bus_if.host_err, 0);
    check("ill_clear_prio_code", bus_if.host_err_code, 0);
    bus_if.host_start = 1;
    tick();
    bus_if.host_start = 0;
    check("ill_start_err",  bus_if.host_err, 1);
    check("ill_start_code", bus_if.host_err_code, 2'b10);
    check("ill_still_busy", bus_if.host_busy, 1);
    bus_if.eng_flag = 0;
    tick();
    check("ill_done",   bus_if.host_done, 1);
    check("ill_cycles", bus_if.host_cycles, 16'(0 + 4 + 1));
    bus_if.eng_addr = 8'd5;
    tick();
    check("ill_mem5_intact", bus_if.eng_d_i, in_ref[5]);

    // Start and clear together in IDLE, then reset in the middle of RUN.
    bus_if.host_start = 1; bus_if.host_clear = 1; bus_if.host_simd = 1; bus_if.eng_flag = 1;
    tick();
    bus_if.host_start = 0; bus_if.host_clear = 0; bus_if.host_simd = 0;
    check("sc_busy",     bus_if.host_busy, 1);
    check("sc_err",      bus_if.host_err, 0);
    check("sc_err_code", bus_if.host_err_code, 0);
    check("sc_done",     bus_if.host_done, 0);
    check("sc_ctrl",     bus_if.eng_ctrl, 32'h3);
    tick(); tick(); tick();
    check("mr_in_run", bus_if.host_busy, 1);
    rst_n = 1'b0;
    tick();
    check("mr_busy",   bus_if.host_busy, 0);
    check("mr_ctrl",   bus_if.eng_ctrl, 0);
    check("mr_done",   bus_if.host_done, 0);
    check("mr_cycles", bus_if.host_cycles, 0);
    rst_n = 1'b1; bus_if.eng_flag = 0;
    tick(); tick(); tick();
    check("mr_no_done", bus_if.host_done, 0);
    check("mr_idle",    bus_if.host_busy, 0);
    for (int i = 0; i < 6; i++) begin
      bus_if.eng_addr = 8'(i);
      tick();
      check("mr_mem_intact", bus_if.eng_d_i, in_ref[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
